// File: rtl/tap_controller_if.sv
// TAP pin bundle: serial test pins, boundary-register hooks and debug taps.
// The master side drives tms/tdi/bsr_tdo; the slave (the controller) drives the rest.
interface tap_controller_if;
  logic       tms;
  logic       tdi;
  logic       bsr_tdo;
  logic       bsr_shift;
  logic       bsr_update;
  logic       bsr_capture;
  logic       tdo;
  logic       tdo_en;
  logic [3:0] ir;
  logic [3:0] tap_state;

  modport master (
    output tms, tdi, bsr_tdo,
    input  bsr_shift, bsr_update, bsr_capture, tdo, tdo_en, ir, tap_state
  );

  modport slave (
    input  tms, tdi, bsr_tdo,
    output bsr_shift, bsr_update, bsr_capture, tdo, tdo_en, ir, tap_state
  );
endinterface

// File: rtl/tap_controller.sv
// TAP controller sequencing an 8-bit boundary scan register.
// Optional feature macro: TAP_IDCODE_EN (adds the 32-bit IDCODE data register
// and makes IDCODE the reset/TLR instruction).
//
// state     | meaning
// TLR       | test-logic-reset, ir held at its reset value
// RTI       | run-test/idle
// SEL_DR    | select DR scan
// CAP_DR    | capture into selected data register
// SHIFT_DR  | shift selected data register, one bit per cycle
// EXIT1_DR  | leave shift, no shift
// PAUSE_DR  | hold data register, no shift
// EXIT2_DR  | resume shift or update
// UPDATE_DR | boundary update strobe
// SEL_IR    | select IR scan
// CAP_IR    | load IR shifter with 4'b0001
// SHIFT_IR  | shift IR shifter, one bit per cycle
// EXIT1_IR  | leave shift, no shift
// PAUSE_IR  | hold IR shifter
// EXIT2_IR  | resume shift or update
// UPDATE_IR | shifter copied to ir on the edge leaving this state
module tap_controller
`ifdef TAP_IDCODE_EN
  #(parameter logic [31:0] IDCODE = 32'h1000_0001)
`endif
(
  input logic        clk,
  input logic        reset,
  tap_controller_if.slave tap
);

  typedef enum logic [3:0] {
    TLR       = 4'hF,
    RTI       = 4'hC,
    SEL_DR    = 4'h7,
    CAP_DR    = 4'h6,
    SHIFT_DR  = 4'h2,
    EXIT1_DR  = 4'h1,
    PAUSE_DR  = 4'h3,
    EXIT2_DR  = 4'h0,
    UPDATE_DR = 4'h5,
    SEL_IR    = 4'h4,
    CAP_IR    = 4'hE,
    SHIFT_IR  = 4'hA,
    EXIT1_IR  = 4'h9,
    PAUSE_IR  = 4'hB,
    EXIT2_IR  = 4'h8,
    UPDATE_IR = 4'hD
  } tap_state_t;

  localparam logic [3:0] INS_BSR = 4'b0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] INS_IDCODE = 4'b0010;
  localparam logic [3:0] IR_RST     = 4'b0010;
`else
  localparam logic [3:0] IR_RST     = 4'b1111;
`endif

  tap_state_t state, state_nxt;
  logic [3:0] ir, ir_nxt;
  logic [3:0] ir_shift;
  logic       bypass;
  logic       bsr_sel, bsr_sel_nxt;
  logic       bsr_shift, bsr_update, bsr_capture, tdo_en;
  logic       tdo;
`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_shift;
`endif

  // Next TAP state from the tms stream.
  always_comb begin
    state_nxt = TLR;
    case (state)
      TLR:       state_nxt = tap.tms ? TLR       : RTI;
      RTI:       state_nxt = tap.tms ? SEL_DR    : RTI;
      SEL_DR:    state_nxt = tap.tms ? SEL_IR    : CAP_DR;
      SEL_IR:    state_nxt = tap.tms ? TLR       : CAP_IR;
      CAP_DR:    state_nxt = tap.tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  state_nxt = tap.tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  state_nxt = tap.tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  state_nxt = tap.tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  state_nxt = tap.tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: state_nxt = tap.tms ? SEL_DR    : RTI;
      CAP_IR:    state_nxt = tap.tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  state_nxt = tap.tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  state_nxt = tap.tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  state_nxt = tap.tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  state_nxt = tap.tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: state_nxt = tap.tms ? SEL_DR    : RTI;
      default:   state_nxt = TLR;
    endcase
  end

  // Next instruction; strobes are registered from next state/ir so they stay Moore-aligned.
  always_comb begin
    ir_nxt = ir;
    if (state == TLR)
      ir_nxt = IR_RST;
    else if (state == UPDATE_IR)
      ir_nxt = ir_shift;
    bsr_sel_nxt = (ir_nxt == INS_BSR);
  end

  // TAP state, instruction, shifters and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TLR;
      ir          <= IR_RST;
      ir_shift    <= 4'b0001;
      bypass      <= 1'b0;
      bsr_sel     <= (IR_RST == INS_BSR);
      bsr_shift   <= 1'b0;
      bsr_update  <= 1'b0;
      bsr_capture <= 1'b0;
      tdo_en      <= 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_shift <= IDCODE;
`endif
    end else begin
      state   <= state_nxt;
      ir      <= ir_nxt;
      bsr_sel <= bsr_sel_nxt;
      case (state)
        CAP_IR:   ir_shift <= 4'b0001;
        SHIFT_IR: ir_shift <= {tap.tdi, ir_shift[3:1]};
        CAP_DR: begin
          bypass <= 1'b0;
`ifdef TAP_IDCODE_EN
          idcode_shift <= IDCODE;
`endif
        end
        SHIFT_DR: begin
          bypass <= tap.tdi;
`ifdef TAP_IDCODE_EN
          idcode_shift <= {tap.tdi, idcode_shift[31:1]};
`endif
        end
        default: ;
      endcase
      bsr_capture <= bsr_sel_nxt && (state_nxt == CAP_DR);
      bsr_shift   <= bsr_sel_nxt && (state_nxt == SHIFT_DR);
      bsr_update  <= bsr_sel_nxt && (state_nxt == UPDATE_DR);
      tdo_en      <= (state_nxt == SHIFT_DR) || (state_nxt == SHIFT_IR);
    end
  end

  // Serial out mux; driven low outside the shift states.
  always_comb begin
    tdo = 1'b0;
    if (state == SHIFT_IR)
      tdo = ir_shift[0];
    else if (state == SHIFT_DR) begin
      if (bsr_sel)
        tdo = tap.bsr_tdo;
`ifdef TAP_IDCODE_EN
      else if (ir == INS_IDCODE)
        tdo = idcode_shift[0];
`endif
      else
        tdo = bypass;
    end
  end

  assign tap.tap_state   = state;
  assign tap.ir          = ir;
  assign tap.bsr_shift   = bsr_shift;
  assign tap.bsr_update  = bsr_update;
  assign tap.bsr_capture = bsr_capture;
  assign tap.tdo_en      = tdo_en;
  assign tap.tdo         = tdo;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, forced TLR, IR load, boundary scan,
// bypass, pause/reset mid-scan, and IDCODE readout when TAP_IDCODE_EN is set.
module tb_tap_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'b0010;
`else
  localparam logic [3:0] IR_RST = 4'b1111;
`endif

  tap_controller_if bus ();

  tap_controller dut (
    .clk   (clk),
    .reset (reset),
    .tap   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // From RTI: scan a 4-bit instruction (LSB first) and return to RTI.
  task automatic load_ir(input logic [3:0] v);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1, 0);
    tick(0, 0);
  endtask

  logic [7:0]  bsr_pat;
  logic [3:0]  byp_in;
  logic [3:0]  byp_exp;
  logic [31:0] id_got;
  int          shift_cnt;

  initial begin
    reset = 1'b1;
    bus.tms = 1'b0;
    bus.tdi = 1'b0;
    bus.bsr_tdo = 1'b0;
    bsr_pat = 8'b1011_0010;
    byp_in  = 4'b1101;   // tdi order 1,0,1,1 (bit 0 first)
    byp_exp = 4'b1010;   // tdo order 0,1,0,1 (bit 0 first)

    // Reset, with tms=0 to show reset wins over tms.
    tick(0, 0);
    tick(0, 0);
    check("rst_state", bus.tap_state, 4'hF);
    check("rst_ir", bus.ir, IR_RST);
    check("rst_strobes", {bus.bsr_shift, bus.bsr_update, bus.bsr_capture}, 3'b000);
    check("rst_tdo_en", bus.tdo_en, 1'b0);
    check("rst_tdo", bus.tdo, 1'b0);
    reset = 1'b0;

`ifdef TAP_IDCODE_EN
    // IDCODE readout straight after reset.
    tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    id_got = '0;
    for (int i = 0; i < 32; i++) begin
      id_got[i] = bus.tdo;
      tick(i == 31, 0);
    end
    check("idcode_val", id_got, 32'h1000_0001);
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
`endif

    // Walk to PAUSE_DR, then five tms=1 to TLR.
    tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    check("walk_pause_dr", bus.tap_state, 4'h3);
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("force_tlr", bus.tap_state, 4'hF);

    // Load IR 4'b0001 with tdo checks.
    tick(0, 0);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    check("shift_ir_state", bus.tap_state, 4'hA);
    check("shift_ir_tdo_en", bus.tdo_en, 1'b1);
    check("ir_tdo0", bus.tdo, 1'b1);
    tick(0, 1);
    check("ir_tdo1", bus.tdo, 1'b0);
    tick(0, 0);
    tick(0, 0);
    tick(1, 0);
    check("exit1_ir_state", bus.tap_state, 4'h9);
    check("exit1_ir_tdo_en", bus.tdo_en, 1'b0);
    tick(1, 0);
    check("update_ir_hold", bus.ir, IR_RST);
    tick(0, 0);
    check("ir_loaded", bus.ir, 4'b0001);

    // Boundary DR scan, 8 SHIFT_DR cycles.
    tick(1, 0);
    check("sel_dr_capture", bus.bsr_capture, 1'b0);
    tick(0, 0);
    check("cap_dr_capture", bus.bsr_capture, 1'b1);
    check("cap_dr_shift", bus.bsr_shift, 1'b0);
    tick(0, 0);
    check("shift_dr_capture", bus.bsr_capture, 1'b0);
    shift_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.bsr_tdo = bsr_pat[i];
      #1;
      if (bus.bsr_shift === 1'b1) shift_cnt++;
      check("bsr_tdo_mirror", bus.tdo, bsr_pat[i]);
      tick(i == 7, 0);
    end
    check("bsr_shift_cycles", shift_cnt, 8);
    check("exit1_dr_shift", bus.bsr_shift, 1'b0);
    check("exit1_dr_tdo", bus.tdo, 1'b0);
    tick(1, 0);
    check("update_dr_pulse", bus.bsr_update, 1'b1);
    tick(0, 0);
    check("update_dr_single", bus.bsr_update, 1'b0);

    // Bypass with ir=4'b1111; bsr_tdo held high to catch a wrong mux leg.
    load_ir(4'b1111);
    check("ir_bypass", bus.ir, 4'b1111);
    bus.bsr_tdo = 1'b1;
    tick(1, 0);
    tick(0, 0);
    check("byp_no_capture", bus.bsr_capture, 1'b0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      check("byp_tdo", bus.tdo, byp_exp[i]);
      check("byp_no_shift", bus.bsr_shift, 1'b0);
      tick(i == 3, byp_in[i]);
    end
    tick(1, 0);
    check("byp_no_update", bus.bsr_update, 1'b0);
    tick(0, 0);

    // Pause mid-DR-scan, then reset while shifting.
    load_ir(4'b0001);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    check("pr_shift_a", bus.bsr_shift, 1'b1);
    tick(0, 0);
    tick(1, 0);
    check("pr_exit1_shift", bus.bsr_shift, 1'b0);
    check("pr_exit1_tdo", bus.tdo, 1'b0);
    tick(0, 0);
    check("pr_pause_shift", bus.bsr_shift, 1'b0);
    check("pr_pause_tdo_en", bus.tdo_en, 1'b0);
    tick(0, 0);
    tick(1, 0);
    check("pr_exit2_shift", bus.bsr_shift, 1'b0);
    tick(0, 0);
    check("pr_shift_b", bus.bsr_shift, 1'b1);
    reset = 1'b1;
    tick(1, 0);
    reset = 1'b0;
    check("pr_rst_state", bus.tap_state, 4'hF);
    check("pr_rst_no_update", bus.bsr_update, 1'b0);
    check("pr_rst_no_shift", bus.bsr_shift, 1'b0);
    check("pr_rst_ir", bus.ir, IR_RST);

    // Partial IR shift discarded by reset.
    tick(0, 0);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 1);
    tick(0, 0);
    reset = 1'b1;
    tick(1, 0);
    reset = 1'b0;
    check("ir_partial_state", bus.tap_state, 4'hF);
    tick(1, 0);
    check("ir_partial_ir", bus.ir, IR_RST);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
